dcache_wt: RTL
==============

Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipeline MEM stage and the word-addressed data memory.
- Serves read hits combinationally in the same cycle.
- On a read miss, stalls the pipeline and fills a 4-word line from memory through a request/ready handshake.
- Every store is forwarded to memory; the pipeline stalls until memory acknowledges it.

Parameters:
- INDEX_BITS, 3, log2 of line count (default 8 lines × 4 words).

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  reset, asynchronous, active-high
- MemRead  input  1  pipeline load request
- MemWrite  input  1  pipeline store request
- Address  input  32  byte address from pipeline; bits [1:0] ignored
- WriteData  input  32  store data
- ReadData  output  32  load data; valid when MemRead=1 and Stall=0
- Stall  output  1  freeze pipeline while high
- MemAddr  output  32  word-aligned address to memory ([1:0]=0)
- MemWData  output  32  store data to memory
- MemRE  output  1  memory read request
- MemWE  output  1  memory write request
- MemRData  input  32  memory read data, valid when MemReady=1
- MemReady  input  1  one-cycle completion pulse for the current request
- HitCount  output  32  load hits since reset
- MissCount  output  32  load misses since reset

Behaviour:
- Address split: offset=Address[3:2]; index=Address[INDEX_BITS+3:4]; tag=Address[31:INDEX_BITS+4].
- Storage per line: valid bit, tag, 4×32 data words. Data/tag arrays have no reset; valid bits do.
- hit = valid[index] && tag matches.
- Reset (async, RST=1): state=IDLE, all valid=0, fill counter=0, HitCount=MissCount=0. Memory request outputs and Stall go low immediately. ReadData=0 while RST=1.
- Reset mid-FILL or mid-WRITE: transaction aborted; the partially filled line stays invalid.
- States: IDLE, FILL, WRITE.
- IDLE:
  - MemRead & hit: ReadData=word[offset], Stall=0, HitCount+1 at edge.
  - MemRead & miss: Stall=1; latch line base address (Address[31:4],4'b0) into reqAddr; counter=0; MissCount+1; go FILL.
  - MemWrite: Stall=1; latch Address and WriteData; go WRITE.
  - MemRead & MemWrite together: treated as a store; no counter update.
  - Neither asserted: Stall=0, no change.
- FILL:
  - MemRE=1; MemAddr=reqAddr+{counter,2'b00}; Stall=1.
  - On MemReady: write MemRData into data[index][counter]; counter+1.
  - On MemReady with counter==3: set valid, write tag, go IDLE.
  - Next cycle the still-held MemRead hits; the hit increments HitCount. A miss therefore counts as one miss plus one hit.
  - Read-miss latency = 1 + 4 memory handshakes + 1 hit cycle.
- WRITE:
  - MemWE=1; MemAddr={latched[31:2],2'b00}; MemWData=latched data.
  - Stall = !MemReady, so the pipeline advances on the edge where MemReady=1.
  - On that edge: if the latched address hits, update the cached word (write-through); on a miss the cache is untouched (no allocate). Go IDLE.
- MemRE and MemWE are never both high. Both are 0 in IDLE.
- MemAddr/MemWData hold stable from request assertion until MemReady.
- MemReady while idle or outside a request: ignored.
- Counters wrap modulo 2^32.
- Fill counter wraps 3→0 on line completion.
- Index wraps naturally. Tags conflicting on the same index evict the old line on fill (no writeback needed).

Test Plan:
- Reset: assert RST asynchronously mid-cycle → Stall, MemRE, MemWE, HitCount and MissCount read 0 before the next edge; any load afterwards misses.
- Cold load 0x0000_0040 with memory returning 0xA0..0xA3 (2-cycle ready latency per word):
  - MemRE addresses 0x40, 0x44, 0x48, 0x4C in order.
  - Stall drops the cycle after the 4th ready; ReadData=0xA0.
  - MissCount=1, HitCount=1.
- Then load 0x0000_004C → hit same cycle, Stall=0, ReadData=0xA3, no MemRE.
- Store 0xDEADBEEF to 0x44 (cached):
  - MemWE with MemAddr=0x44 until ready.
  - Stall falls in the ready cycle.
  - Subsequent load 0x44 hits with 0xDEADBEEF.
- Store 0x1234 to uncached 0x200 → memory write issued; following load 0x200 misses (no allocate).
- Conflict: with INDEX_BITS=3, load 0x40 then 0xC0 (same index, different tag) → second load misses and refills; reload 0x40 misses again; MissCount=3.
- RST pulse during the 2nd word of a fill → MemRE drops immediately; a reload of the same address performs a full 4-word fill.

Source files
------------

// File: rtl/dcache_wt_if.sv
// dcache_wt_if: the bus bundle around the write-through data cache.
//   Pipeline side : MemRead, MemWrite, Address, WriteData -> ReadData, Stall
//   Memory side   : MemAddr, MemWData, MemRE, MemWE      <- MemRData, MemReady
//   Statistics    : HitCount, MissCount
// Modports: slave  = the cache itself
//           master = the environment (pipeline + data memory)
//
// Handshake: a memory request is MemRE or MemWE held high (never both) with
// MemAddr/MemWData stable until the memory answers with a one-cycle MemReady
// pulse; the request is consumed on the rising edge where MemReady=1 (read
// data sampled from MemRData on that edge). MemReady outside a request is
// ignored. On the pipeline side, a load/store is complete on the rising edge
// where Stall=0 while it is asserted.
interface dcache_wt_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemRE;
  logic        MemWE;
  logic [31:0] MemRData;
  logic        MemReady;
  logic [31:0] HitCount;
  logic [31:0] MissCount;

  modport slave (
    input  MemRead, MemWrite, Address, WriteData, MemRData, MemReady,
    output ReadData, Stall, MemAddr, MemWData, MemRE, MemWE, HitCount, MissCount
  );

  modport master (
    output MemRead, MemWrite, Address, WriteData, MemRData, MemReady,
    input  ReadData, Stall, MemAddr, MemWData, MemRE, MemWE, HitCount, MissCount
  );
endinterface

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache.
//   Read hits return data combinationally; a read miss stalls and fills a
//   4-word line; every store is forwarded to memory and stalls until acked.
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   bus          dcache_wt_if.slave (pipeline, memory and counter signals)
//   o_dbg_state  current FSM state (0=IDLE, 1=FILL, 2=WRITE)
module dcache_wt #(
  parameter int INDEX_BITS = 3
) (
  input  logic       CLK,
  input  logic       RST,
  dcache_wt_if.slave bus,
  output logic [1:0] o_dbg_state
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            r_state;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [31:0]       r_data [LINES][4];
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [1:0]        r_cnt;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;

  // Pipeline-side lookup.
  logic [1:0]            w_off;
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  // Lookup of the latched request address (fill target / store address).
  logic [1:0]            w_roff;
  logic [INDEX_BITS-1:0] w_ridx;
  logic [TAG_W-1:0]      w_rtag;
  logic                  w_rhit;
  logic                  w_ld_req;
  logic                  w_st_req;
  logic                  w_fill_ack;
  logic                  w_wr_ack;
  logic                  w_stall;
  logic                  w_unused;

  assign w_off  = bus.Address[3:2];
  assign w_idx  = bus.Address[INDEX_BITS+3:4];
  assign w_tag  = bus.Address[31:INDEX_BITS+4];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign w_roff = r_mem_addr[3:2];
  assign w_ridx = r_mem_addr[INDEX_BITS+3:4];
  assign w_rtag = r_mem_addr[31:INDEX_BITS+4];
  assign w_rhit = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);

  // A simultaneous load+store is handled purely as a store.
  assign w_st_req   = bus.MemWrite;
  assign w_ld_req   = bus.MemRead && !bus.MemWrite;
  assign w_fill_ack = (r_state == S_FILL)  && bus.MemReady;
  assign w_wr_ack   = (r_state == S_WRITE) && bus.MemReady;

  // Byte-offset bits carry no information for a word cache.
  assign w_unused = &{1'b0, bus.Address[1:0]};

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = (w_ld_req && !w_hit) || w_st_req;
      S_FILL:  w_stall = 1'b1;
      // The store retires on the edge where memory acknowledges it.
      S_WRITE: w_stall = !bus.MemReady;
      default: w_stall = 1'b0;
    endcase
    // Reset releases the pipeline immediately, even with a request held.
    if (RST) w_stall = 1'b0;
  end

  assign bus.Stall     = w_stall;
  assign bus.ReadData  = (!RST && r_state == S_IDLE && bus.MemRead && w_hit)
                         ? r_data[w_idx][w_off] : 32'd0;
  assign bus.MemAddr   = r_mem_addr;
  assign bus.MemWData  = r_mem_wdata;
  assign bus.MemRE     = r_mem_re;
  assign bus.MemWE     = r_mem_we;
  assign bus.HitCount  = r_hit_cnt;
  assign bus.MissCount = r_miss_cnt;
  assign o_dbg_state   = r_state;

  // Control FSM with registered memory-request outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_cnt       <= 2'd0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_hit_cnt   <= 32'd0;
      r_miss_cnt  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_st_req) begin
            r_mem_addr  <= {bus.Address[31:2], 2'b00};
            r_mem_wdata <= bus.WriteData;
            r_mem_we    <= 1'b1;
            r_state     <= S_WRITE;
          end else if (w_ld_req) begin
            if (w_hit) begin
              r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
              r_miss_cnt     <= r_miss_cnt + 32'd1;
              r_mem_addr     <= {bus.Address[31:4], 4'b0000};
              r_cnt          <= 2'd0;
              // The victim line is invalid while it is being overwritten,
              // so an aborted fill never leaves a half-updated valid line.
              r_valid[w_idx] <= 1'b0;
              r_mem_re       <= 1'b1;
              r_state        <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (bus.MemReady) begin
            r_cnt           <= r_cnt + 2'd1;
            // Word offset of the next request tracks the fill counter.
            r_mem_addr[3:2] <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_valid[w_ridx] <= 1'b1;
              r_mem_re        <= 1'b0;
              r_state         <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          if (bus.MemReady) begin
            r_mem_we <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag/data storage, deliberately without reset.
  always_ff @(posedge CLK) begin
    if (w_fill_ack) begin
      r_data[w_ridx][r_cnt] <= bus.MemRData;
      if (r_cnt == 2'd3) r_tag[w_ridx] <= w_rtag;
    end else if (w_wr_ack && w_rhit) begin
      // Write-through update of a cached word; store misses do not allocate.
      r_data[w_ridx][w_roff] <= r_mem_wdata;
    end
  end
endmodule
